// File: rtl/pipe_memory_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM encoding and the
// latched bus command.
package pipe_memory_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BSEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [BSEL_W-1:0] bsel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/pipe_memory_arbiter_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module pipe_arbiter_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                            cnt_d = '0;
    else if (inc_i && cnt_q != W'(MAX))   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_memory_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one memory bus, with
// fetch anti-starvation and a per-transaction ready timeout.
module pipe_memory_arbiter
  import pipe_memory_arbiter_pkg::*;
#(
  parameter int FETCH_STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetchEnable,
  input  logic [ADDR_W-1:0] fetchAddress,
  output logic              fetchBusy,
  output logic [DATA_W-1:0] fetchData,
  output logic              fetchError,
  input  logic              dataEnable,
  input  logic              dataWriteEnable,
  input  logic [BSEL_W-1:0] dataByteSelect,
  input  logic [ADDR_W-1:0] dataAddress,
  input  logic [DATA_W-1:0] dataWriteData,
  output logic              dataBusy,
  output logic [DATA_W-1:0] dataReadData,
  output logic              dataError,
  output logic              memEnable,
  output logic              memWriteEnable,
  output logic [BSEL_W-1:0] memByteSelect,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  input  logic              memReady,
  input  logic [DATA_W-1:0] memReadData
);

  localparam int SW = $clog2(FETCH_STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e        state_q, state_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              ferr_q, ferr_d, derr_q, derr_d;
  logic [DATA_W-1:0] frd_q, drd_q;
  logic [SW-1:0]     starve;
  logic [TW-1:0]     tcnt;
  logic              active, fcmpl, dcmpl, tmo, starve_full;
  logic              grant_f, grant_d;

  assign active      = (state_q != ST_IDLE);
  assign fcmpl       = (state_q == ST_FETCH) && memReady;
  assign dcmpl       = (state_q == ST_DATA)  && memReady;
  // A ready in the final allowed cycle is still a normal completion.
  assign tmo         = active && !memReady && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign starve_full = (starve == SW'(FETCH_STARVE_LIMIT));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    grant_f = 1'b0;
    grant_d = 1'b0;
    ferr_d  = 1'b0;
    derr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dataEnable && !(fetchEnable && starve_full)) begin
          grant_d = 1'b1;
          state_d = ST_DATA;
          cmd_d   = '{we: dataWriteEnable, bsel: dataByteSelect,
                      addr: dataAddress, wdata: dataWriteData};
        end else if (fetchEnable) begin
          grant_f = 1'b1;
          state_d = ST_FETCH;
          cmd_d   = '{we: 1'b0, bsel: {BSEL_W{1'b1}},
                      addr: fetchAddress, wdata: '0};
        end
      end
      ST_FETCH: begin
        if (memReady)  state_d = ST_IDLE;
        else if (tmo) begin
          state_d = ST_IDLE;
          ferr_d  = 1'b1;
        end
      end
      ST_DATA: begin
        if (memReady)  state_d = ST_IDLE;
        else if (tmo) begin
          state_d = ST_IDLE;
          derr_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      ferr_q  <= 1'b0;
      derr_q  <= 1'b0;
      frd_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ferr_q  <= ferr_d;
      derr_q  <= derr_d;
      // Results for a requester that already walked away are dropped.
      if (fcmpl && fetchEnable) frd_q <= memReadData;
      if (dcmpl && dataEnable)  drd_q <= memReadData;
    end
  end

  pipe_arbiter_counter #(.MAX(FETCH_STARVE_LIMIT), .W(SW)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!fetchEnable || grant_f),
    .inc_i (grant_d),
    .cnt_o (starve)
  );

  pipe_arbiter_counter #(.MAX(TIMEOUT_CYCLES), .W(TW)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!active),
    .inc_i (active && !memReady),
    .cnt_o (tcnt)
  );

  assign memEnable      = active;
  assign memWriteEnable = active && cmd_q.we;
  assign memByteSelect  = cmd_q.bsel;
  assign memAddress     = cmd_q.addr;
  assign memWriteData   = cmd_q.wdata;

  assign fetchBusy    = fetchEnable && !fcmpl && !ferr_q;
  assign dataBusy     = dataEnable  && !dcmpl && !derr_q;
  assign fetchData    = (fcmpl && fetchEnable) ? memReadData : frd_q;
  assign dataReadData = (dcmpl && dataEnable)  ? memReadData : drd_q;
  assign fetchError   = ferr_q;
  assign dataError    = derr_q;

endmodule

// File: tb/tb_pipe_memory_arbiter.sv
// Directed + randomized bench for pipe_memory_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_pipe_memory_arbiter;

  localparam int LIM = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchEnable, dataEnable, dataWriteEnable, memReady;
  logic [31:0] fetchAddress, dataAddress, dataWriteData, memReadData;
  logic [3:0]  dataByteSelect;
  logic        fetchBusy, fetchError, dataBusy, dataError;
  logic [31:0] fetchData, dataReadData;
  logic        memEnable, memWriteEnable;
  logic [3:0]  memByteSelect;
  logic [31:0] memAddress, memWriteData;

  int vecs = 0;
  int errs = 0;

  // Model: owner 0 = bus idle, 1 = fetch, 2 = data.
  int          m_own, m_wait, m_starve, m_err;
  logic        m_fdone, m_ddone, m_we;
  logic [3:0]  m_bsel;
  logic [31:0] m_addr, m_wdata, m_fhold, m_dhold;

  pipe_memory_arbiter #(.FETCH_STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .fetchEnable(fetchEnable), .fetchAddress(fetchAddress),
    .fetchBusy(fetchBusy), .fetchData(fetchData), .fetchError(fetchError),
    .dataEnable(dataEnable), .dataWriteEnable(dataWriteEnable),
    .dataByteSelect(dataByteSelect), .dataAddress(dataAddress),
    .dataWriteData(dataWriteData),
    .dataBusy(dataBusy), .dataReadData(dataReadData), .dataError(dataError),
    .memEnable(memEnable), .memWriteEnable(memWriteEnable),
    .memByteSelect(memByteSelect), .memAddress(memAddress),
    .memWriteData(memWriteData),
    .memReady(memReady), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_wait = 0; m_starve = 0; m_err = 0;
    m_fdone = 0; m_ddone = 0;
    m_we = 0; m_bsel = '0; m_addr = '0; m_wdata = '0;
    m_fhold = '0; m_dhold = '0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    int nerr;
    nerr = 0; m_fdone = 0; m_ddone = 0;
    if (m_own != 0) begin
      if (memReady) begin
        if (m_own == 1) begin m_fdone = 1; if (fetchEnable) m_fhold = memReadData; end
        else            begin m_ddone = 1; if (dataEnable)  m_dhold = memReadData; end
        m_own = 0;
      end else if (m_wait + 1 == TMO) begin
        nerr = m_own;
        if (m_own == 1) m_fdone = 1; else m_ddone = 1;
        m_own = 0;
      end else begin
        m_wait++;
      end
      if (!fetchEnable) m_starve = 0;
    end else begin
      m_wait = 0;
      if (dataEnable && !(fetchEnable && m_starve == LIM)) begin
        m_own = 2; m_we = dataWriteEnable; m_bsel = dataByteSelect;
        m_addr = dataAddress; m_wdata = dataWriteData;
        m_starve = !fetchEnable ? 0 : (m_starve < LIM ? m_starve + 1 : LIM);
      end else if (fetchEnable) begin
        m_own = 1; m_we = 0; m_bsel = 4'hF; m_addr = fetchAddress; m_wdata = '0;
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
    end
    m_err = nerr;
  endtask

  task automatic settle();
    logic fcm, dcm;
    #1;
    fcm = (m_own == 1) && memReady;
    dcm = (m_own == 2) && memReady;
    chk("memEnable",      {31'b0, memEnable},      {31'b0, m_own != 0});
    chk("memWriteEnable", {31'b0, memWriteEnable}, {31'b0, (m_own != 0) && m_we});
    chk("memAddress",     memAddress,              m_addr);
    chk("memByteSelect",  {28'b0, memByteSelect},  {28'b0, m_bsel});
    chk("memWriteData",   memWriteData,            m_wdata);
    chk("fetchBusy",      {31'b0, fetchBusy},      {31'b0, fetchEnable && !fcm && m_err != 1});
    chk("dataBusy",       {31'b0, dataBusy},       {31'b0, dataEnable && !dcm && m_err != 2});
    chk("fetchData",      fetchData, (fcm && fetchEnable) ? memReadData : m_fhold);
    chk("dataReadData",   dataReadData, (dcm && dataEnable) ? memReadData : m_dhold);
    chk("fetchError",     {31'b0, fetchError},     {31'b0, m_err == 1});
    chk("dataError",      {31'b0, dataError},      {31'b0, m_err == 2});
  endtask

  task automatic advance();
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ndata, n;
    logic seen;

    rst = 1'b1;
    fetchEnable = 0; fetchAddress = '0;
    dataEnable = 0; dataWriteEnable = 0; dataByteSelect = '0;
    dataAddress = '0; dataWriteData = '0;
    memReady = 0; memReadData = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset: bus quiet, busy follows enable.
    fetchEnable = 1;
    settle();
    chk("rst_fetchBusy", {31'b0, fetchBusy}, 32'd1);
    chk("rst_memEnable", {31'b0, memEnable}, 32'd0);
    advance();
    fetchEnable = 0;
    advance();
    rst = 1'b0;
    settle(); advance();

    // Fetch-only, ready on the third FETCH cycle.
    fetchEnable = 1; fetchAddress = 32'h100;
    settle(); advance();
    settle(); advance();
    settle(); advance();
    memReady = 1; memReadData = 32'hDEADBEEF;
    settle();
    chk("fo_addr",  memAddress, 32'h100);
    chk("fo_busy",  {31'b0, fetchBusy}, 32'd0);
    chk("fo_data",  fetchData, 32'hDEADBEEF);
    advance();
    fetchEnable = 0; memReady = 0; memReadData = 32'h0BADF00D;
    settle();
    chk("fo_hold", fetchData, 32'hDEADBEEF);
    advance();

    // Simultaneous: data first, then one idle cycle, then fetch.
    fetchEnable = 1; fetchAddress = 32'h180;
    dataEnable = 1; dataAddress = 32'h200; dataWriteEnable = 1;
    dataByteSelect = 4'h3; dataWriteData = 32'h55AA;
    settle(); advance();
    memReady = 1; memReadData = 32'h1111;
    settle();
    chk("sim_daddr", memAddress, 32'h200);
    chk("sim_dwe",   {31'b0, memWriteEnable}, 32'd1);
    advance();
    dataEnable = 0; memReady = 0;
    settle();
    chk("sim_gap", {31'b0, memEnable}, 32'd0);
    advance();
    memReady = 1; memReadData = 32'h2222;
    settle();
    chk("sim_faddr", memAddress, 32'h180);
    chk("sim_fen",   {31'b0, memEnable}, 32'd1);
    advance();
    fetchEnable = 0; memReady = 0;
    settle(); advance();

    // Starvation: fetch waits out exactly LIM data transactions.
    fetchEnable = 1; fetchAddress = 32'h300;
    dataEnable = 1; dataAddress = 32'h400; dataWriteEnable = 0; dataByteSelect = 4'hF;
    memReady = 1; memReadData = 32'hCAFE0001;
    ndata = 0; seen = 0; n = 0;
    while (!seen && n < 40) begin
      settle();
      if (memEnable && memAddress == 32'h400) ndata++;
      if (memEnable && memAddress == 32'h300) seen = 1;
      else advance();
      n++;
    end
    dataEnable = 0;
    advance();
    fetchEnable = 0; memReady = 0;
    chk("starve_ndata", ndata, LIM);
    chk("starve_fetch", {31'b0, seen}, 32'd1);
    settle(); advance();

    // Timeout on a data write.
    dataEnable = 1; dataWriteEnable = 1; dataAddress = 32'h700;
    dataWriteData = 32'hA5A5A5A5; dataByteSelect = 4'hF;
    n = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      settle();
      if (memEnable) n++;
      if (dataError) begin
        seen = 1;
        chk("tmo_idle", {31'b0, memEnable}, 32'd0);
        chk("tmo_busy", {31'b0, dataBusy}, 32'd0);
        dataEnable = 0;
      end
      advance();
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_seen", {31'b0, seen}, 32'd1);

    // Abort: data read abandoned mid-flight.
    dataEnable = 1; dataWriteEnable = 0; dataAddress = 32'h500;
    settle(); advance();
    settle(); advance();
    dataEnable = 0;
    settle();
    chk("abt_men",  {31'b0, memEnable}, 32'd1);
    chk("abt_busy", {31'b0, dataBusy}, 32'd0);
    advance();
    memReady = 1; memReadData = 32'h12345678;
    settle();
    chk("abt_men2", {31'b0, memEnable}, 32'd1);
    chk("abt_rd",   dataReadData, 32'hCAFE0001);
    advance();
    memReady = 0;
    settle();
    chk("abt_done", {31'b0, memEnable}, 32'd0);
    chk("abt_hold", dataReadData, 32'hCAFE0001);
    advance();

    // Async reset in the middle of a FETCH cycle.
    fetchEnable = 1; fetchAddress = 32'h600;
    settle(); advance();
    settle();
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_men",  {31'b0, memEnable}, 32'd0);
    chk("arst_addr", memAddress, 32'h0);
    fetchEnable = 0; memReady = 1;
    advance();
    rst = 1'b0;
    settle(); advance();
    settle(); advance();
    memReady = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (!fetchEnable && $urandom_range(0, 1) == 1) begin
        fetchEnable = 1; fetchAddress = $urandom;
      end
      if (!dataEnable && $urandom_range(0, 2) == 0) begin
        dataEnable = 1; dataWriteEnable = 1'($urandom_range(0, 1));
        dataByteSelect = 4'($urandom); dataAddress = $urandom; dataWriteData = $urandom;
      end else if (dataEnable && m_own == 2 && $urandom_range(0, 19) == 0) begin
        dataEnable = 0;
      end
      memReady = ($urandom_range(0, 9) < 4);
      memReadData = $urandom;
      settle();
      advance();
      if (m_fdone) fetchEnable = 0;
      if (m_ddone) dataEnable = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pipe_memory_arbiter.md
PIPE_MEMORY_ARBITER -- requirements
Module: pipe_memory_arbiter

Interface
REQ-001 SHALL have parameter FETCH_STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch is pending.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles to wait for memReady before aborting.
REQ-003 SHALL have ports `clk` (input, 1, sole clock) and `rst` (input, 1, asynchronous active-high reset).
REQ-004 SHALL have fetch-port inputs: fetchEnable (1, request), fetchAddress (32, word address).
REQ-005 SHALL have fetch-port outputs: fetchBusy (1, request not yet complete), fetchData (32, read data), fetchError (1, timeout).
REQ-006 SHALL have data-port inputs: dataEnable (1), dataWriteEnable (1), dataByteSelect (4), dataAddress (32), dataWriteData (32).
REQ-007 SHALL have data-port outputs: dataBusy (1), dataReadData (32), dataError (1, timeout).
REQ-008 SHALL have memory-bus outputs: memEnable (1), memWriteEnable (1), memByteSelect (4), memAddress (32), memWriteData (32).
REQ-009 SHALL have memory-bus inputs: memReady (1, completion strobe), memReadData (32).

Function
REQ-010 SHALL use an FSM with states IDLE, FETCH and DATA.
REQ-011 IDLE: SHALL move to DATA if dataEnable; else to FETCH if fetchEnable; else stay in IDLE.
REQ-012 Exception to REQ-011: if both requests are present and starveCount==FETCH_STARVE_LIMIT, SHALL grant FETCH.
REQ-013 On IDLE exit, SHALL latch the granted port's address, write enable, byte select and write data into bus registers.
REQ-014 While in FETCH or DATA, memEnable SHALL be 1, driven from the latched registers; memWriteEnable SHALL be 0 in FETCH.
REQ-015 A transaction completes in the cycle where memEnable && memReady; the FSM SHALL then return to IDLE.
REQ-016 No back-to-back grant: SHALL hold a minimum of one IDLE cycle between transactions.
REQ-017 Completion-cycle outputs: granted port's busy SHALL be 0; fetchData/dataReadData SHALL equal memReadData (combinational pass-through).
REQ-018 After completion, read data SHALL be held in a register until the next completion on the same port.
REQ-019 Busy rule: fetchBusy = fetchEnable && !(fetch completion); dataBusy = dataEnable && !(data completion).
REQ-020 A requester dropping enable mid-transaction SHALL NOT abort the bus transaction; it runs to completion and the result is discarded.
REQ-021 starveCount SHALL increment on each data grant made while fetchEnable=1.
REQ-022 starveCount SHALL clear on any fetch grant and whenever fetchEnable=0.
REQ-023 starveCount SHALL saturate at FETCH_STARVE_LIMIT.
REQ-024 Timeout counter SHALL clear on IDLE exit and increment each cycle in FETCH/DATA without memReady.
REQ-025 On reaching TIMEOUT_CYCLES: SHALL return to IDLE, drop memEnable next cycle, and pulse the granted port's error output for 1 cycle with busy=0.
REQ-026 memReady while in IDLE SHALL be ignored.
REQ-027 memReady and timeout in the same cycle SHALL be treated as a normal completion with no error.

Reset
REQ-028 On rst: SHALL set state=IDLE, memEnable=0, memWriteEnable=0, memByteSelect=0, memAddress=0, memWriteData=0.
REQ-029 On rst: SHALL set held read data=0, errors=0, starveCount=0, timeout counter=0.
REQ-030 During reset, busy outputs SHALL equal their enable inputs.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction; a later memReady SHALL be ignored per REQ-026.

Structure
REQ-032 FSM state encodings and the bus-command field widths SHALL live in a shared pipe package.
REQ-033 SHALL contain one sub-module, pipe_arbiter_counter, a saturating/clearable counter instantiated for starveCount and the timeout counter.

Verification
REQ-034 Fetch-only test: fetchEnable=1, fetchAddress=0x100, memReady on the 3rd FETCH cycle -> memAddress=0x100, fetchBusy low that cycle, fetchData=memReadData=0xDEADBEEF.
REQ-035 Simultaneous request test: fetch and data enables both asserted in IDLE -> DATA granted first; FETCH granted after completion plus one IDLE cycle.
REQ-036 Starvation test: fetch held, 5 back-to-back data requests, LIMIT=4 -> fetch granted after the 4th data transaction.
REQ-037 Timeout test: DATA write with memReady never asserted, TIMEOUT_CYCLES=8 -> dataError pulses after 8 cycles and the FSM is in IDLE.
REQ-038 Abort test: dataEnable dropped mid-DATA -> memEnable held until memReady; no dataBusy glitch; held dataReadData unchanged.
REQ-039 Async reset test: rst asserted mid-FETCH between clock edges -> memEnable=0 immediately; subsequent memReady ignored.
